writeback_stage: RTL and testbench
==================================

# writeback_stage

Final pipeline stage after execute. Latches one executed instruction per handshake and commits its result:
- register results go to the 16 × 64-bit architectural register file, which lives in this block;
- memory-destination results go out as a store request.

It also serves the two combinational register read ports used by operand fetch, counts retired instructions, and halts the core on a kill (return opcodes).

## Interface
Parameters:
- NUM_REGS, 16, architectural register count; register code is 4 bits.
- DATA_W, 64, register and ALU width.

Ports (bit order [0:N-1], MSB first):
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- exValidIn  in  1  execute presents an instruction this cycle
- wbReadyOut  out  1  stage can accept an instruction this cycle
- isExecuteSuccessfulIn  in  1  execute recognised the opcode
- killIn  in  1  instruction ends the program
- aluResultIn  in  64  primary result
- aluResultSpecialIn  in  64  high half of a MUL/IMUL result
- destRegIn  in  4  primary destination register code
- destRegSpecialIn  in  4  special destination register code (RDX)
- destRegSpecialValidIn  in  1  write the special destination too
- isMemoryAccessDestIn  in  1  destination is memory, not a register
- memoryAddressDestIn  in  64  store address
- currentRipIn  in  64  RIP of the instruction
- readReg1In, readReg2In  in  4  operand-fetch read addresses
- readVal1Out, readVal2Out  out  64  read data (combinational)
- storeReqOut  out  1  store request valid
- storeAddrOut  out  64  store address
- storeDataOut  out  64  store data
- storeAckIn  in  1  memory accepted the store
- retiredCountOut  out  64  instructions retired
- lastRipOut  out  64  RIP of the most recently retired instruction
- haltOut  out  1  kill retired; core stopped

## Operation
State machine with four states: IDLE, COMMIT, STORE, HALTED.
- **wbReadyOut** = 1 only in IDLE.
- **Capture:** when exValidIn && wbReadyOut, latch all inputs into the WB register.
  - killIn = 1 → HALTED.
  - isExecuteSuccessfulIn = 0 → stay in IDLE. Nothing is written and nothing is retired.
  - isMemoryAccessDestIn = 1 → STORE.
  - otherwise → COMMIT.
- **COMMIT:**
  - Write the latched aluResult to regs[destReg].
  - If destRegSpecialValid, also write aluResultSpecial to regs[destRegSpecial] in the same cycle.
  - If both writes target the same register, the special write wins.
  - Retire, then go to IDLE.
- **STORE:**
  - Hold storeReqOut = 1, storeAddrOut = latched address, storeDataOut = latched aluResult. These stay stable until storeAckIn.
  - On the cycle storeAckIn = 1: retire, then go to IDLE.
  - storeAckIn outside STORE is ignored.
- **HALTED:**
  - haltOut = 1 and the kill instruction counts as retired.
  - No further captures. Only reset leaves HALTED.
- **Retire:** retiredCountOut += 1 (wraps modulo 2^64) and lastRipOut ← latched RIP.
- **Read ports:** combinational, regs[readRegN]. Register code 0 is an ordinary register (RAX), not hard-wired.

## Timing
- Capture to register update: the write takes effect at the clock edge ending COMMIT, so the new value is visible on the read ports the cycle after COMMIT.
- Throughput: one register instruction per 2 cycles (IDLE, COMMIT).
- Store latency: 1 capture cycle plus the cycles spent waiting for storeAckIn (≥1).
- Reset takes priority over everything, including mid-STORE. storeReqOut drops the next cycle and the in-flight store is lost. Reset values:
  - state = IDLE, wbReadyOut = 1;
  - all registers, retiredCountOut, lastRipOut, storeAddrOut, storeDataOut = 0;
  - storeReqOut = 0, haltOut = 0.
- Outputs are registered, except wbReadyOut (decoded from the registered state) and readVal*.

## Configuration
WB_BYPASS_EN:
- **Defined:** during COMMIT, a read whose address matches a register being written returns the value being written. If both writes match, the special value is returned. This gives same-cycle visibility.
- **Undefined:** the read ports return regs[] only, i.e. the pre-write value during COMMIT.

## Structure
- Shared package `babelfish_pkg`:
  - `wb_state_t` enum for the four states;
  - DATA_W and NUM_REGS;
  - constant REG_RAX = 4'h0;
  - constant REG_RDX = 4'h2.
- One natural sub-module, `register_file`: 16 × 64, two combinational read ports, two write ports with port B priority, and the WB_BYPASS_EN bypass inside it.

## Test plan
- **Reset, then register commit:** reset; capture destReg = 3, aluResult = 64'h1234 → wbReadyOut = 0 for exactly one cycle; the next cycle readReg1In = 3 reads 64'h1234; retiredCountOut = 1.
- **MUL dual write:** destReg = 0, aluResult = 64'h5, destRegSpecial = 2, aluResultSpecial = 64'h9, special valid → RAX = 5 and RDX = 9. A repeat with both codes = 2 leaves RDX = 9.
- **Store with delayed ack:** isMemoryAccessDest, address 64'h1000, data 64'hAB; storeAckIn held low 3 cycles → storeReqOut/storeAddrOut/storeDataOut stable for 4 cycles; retire on the ack cycle; register file unchanged.
- **Kill:** killIn with currentRipIn = 64'h400 → haltOut = 1, lastRipOut = 64'h400; further exValidIn is ignored and wbReadyOut stays 0 until reset.
- **Unsuccessful op and reset mid-store:**
  - isExecuteSuccessfulIn = 0 → no write, count unchanged.
  - Reset asserted during STORE → storeReqOut = 0 the next cycle, state IDLE, count = 0.
- **Bypass:** read destReg during COMMIT → new value with WB_BYPASS_EN defined, old value without it.

Source files
------------

// File: rtl/babelfish_pkg.sv
// Shared types and constants for the babelfish core pipeline.
package babelfish_pkg;

    localparam int DATA_W   = 64;
    localparam int NUM_REGS = 16;

    localparam logic [3:0] REG_RAX = 4'h0;
    localparam logic [3:0] REG_RDX = 4'h2;

    typedef enum logic [1:0] {
        WB_IDLE   = 2'd0,
        WB_COMMIT = 2'd1,
        WB_STORE  = 2'd2,
        WB_HALTED = 2'd3
    } wb_state_t;

endpackage

// File: rtl/register_file.sv
// Architectural register file: two combinational read ports, two write ports (B wins).
// WB_BYPASS_EN: forward in-flight write data to the read ports in the same cycle.
module register_file #(
    parameter int NUM_REGS = babelfish_pkg::NUM_REGS,
    parameter int DATA_W   = babelfish_pkg::DATA_W,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              weA,
    input  logic [AW-1:0]     waddrA,
    input  logic [DATA_W-1:0] wdataA,
    input  logic              weB,
    input  logic [AW-1:0]     waddrB,
    input  logic [DATA_W-1:0] wdataB,
    input  logic [AW-1:0]     raddr1,
    input  logic [AW-1:0]     raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Port B is assigned last so it takes the register when both ports collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            if (weA) regs[waddrA] <= wdataA;
            if (weB) regs[waddrB] <= wdataB;
        end
    end

    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
`ifdef WB_BYPASS_EN
        if (weA && waddrA == raddr1) rdata1 = wdataA;
        if (weB && waddrB == raddr1) rdata1 = wdataB;
        if (weA && waddrA == raddr2) rdata2 = wdataA;
        if (weB && waddrB == raddr2) rdata2 = wdataB;
`endif
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: commits results to the register file or issues a store, counts retirements.
// WB_BYPASS_EN (in register_file) gives same-cycle read visibility of COMMIT writes.
module writeback_stage #(
    parameter int NUM_REGS = babelfish_pkg::NUM_REGS,
    parameter int DATA_W   = babelfish_pkg::DATA_W,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     exValidIn,
    output logic                     wbReadyOut,
    input  logic                     isExecuteSuccessfulIn,
    input  logic                     killIn,
    input  logic [DATA_W-1:0]        aluResultIn,
    input  logic [DATA_W-1:0]        aluResultSpecialIn,
    input  logic [AW-1:0]            destRegIn,
    input  logic [AW-1:0]            destRegSpecialIn,
    input  logic                     destRegSpecialValidIn,
    input  logic                     isMemoryAccessDestIn,
    input  logic [DATA_W-1:0]        memoryAddressDestIn,
    input  logic [DATA_W-1:0]        currentRipIn,
    input  logic [AW-1:0]            readReg1In,
    input  logic [AW-1:0]            readReg2In,
    output logic [DATA_W-1:0]        readVal1Out,
    output logic [DATA_W-1:0]        readVal2Out,
    output logic                     storeReqOut,
    output logic [DATA_W-1:0]        storeAddrOut,
    output logic [DATA_W-1:0]        storeDataOut,
    input  logic                     storeAckIn,
    output logic [DATA_W-1:0]        retiredCountOut,
    output logic [DATA_W-1:0]        lastRipOut,
    output logic                     haltOut,
    output babelfish_pkg::wb_state_t stateDbgOut
);
    import babelfish_pkg::*;

    wb_state_t         state;
    logic [DATA_W-1:0] wbAlu;
    logic [DATA_W-1:0] wbAluSpecial;
    logic [AW-1:0]     wbDest;
    logic [AW-1:0]     wbDestSpecial;
    logic              wbSpecialValid;
    logic [DATA_W-1:0] wbRip;

    // Handshake: an instruction transfers on a clock edge where exValidIn && wbReadyOut;
    // wbReadyOut is high only in IDLE, and execute must hold its payload until then.
    assign wbReadyOut  = (state == WB_IDLE);
    assign stateDbgOut = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= WB_IDLE;
            wbAlu           <= '0;
            wbAluSpecial    <= '0;
            wbDest          <= '0;
            wbDestSpecial   <= '0;
            wbSpecialValid  <= 1'b0;
            wbRip           <= '0;
            storeReqOut     <= 1'b0;
            storeAddrOut    <= '0;
            storeDataOut    <= '0;
            retiredCountOut <= '0;
            lastRipOut      <= '0;
            haltOut         <= 1'b0;
        end else begin
            case (state)
                WB_IDLE: begin
                    if (exValidIn) begin
                        wbAlu          <= aluResultIn;
                        wbAluSpecial   <= aluResultSpecialIn;
                        wbDest         <= destRegIn;
                        wbDestSpecial  <= destRegSpecialIn;
                        wbSpecialValid <= destRegSpecialValidIn;
                        wbRip          <= currentRipIn;
                        // A kill retires at capture so halt and the count land together.
                        if (killIn) begin
                            state           <= WB_HALTED;
                            haltOut         <= 1'b1;
                            retiredCountOut <= retiredCountOut + DATA_W'(1);
                            lastRipOut      <= currentRipIn;
                        end else if (!isExecuteSuccessfulIn) begin
                            state <= WB_IDLE;
                        end else if (isMemoryAccessDestIn) begin
                            state        <= WB_STORE;
                            storeReqOut  <= 1'b1;
                            storeAddrOut <= memoryAddressDestIn;
                            storeDataOut <= aluResultIn;
                        end else begin
                            state <= WB_COMMIT;
                        end
                    end
                end
                WB_COMMIT: begin
                    retiredCountOut <= retiredCountOut + DATA_W'(1);
                    lastRipOut      <= wbRip;
                    state           <= WB_IDLE;
                end
                WB_STORE: begin
                    if (storeAckIn) begin
                        storeReqOut     <= 1'b0;
                        retiredCountOut <= retiredCountOut + DATA_W'(1);
                        lastRipOut      <= wbRip;
                        state           <= WB_IDLE;
                    end
                end
                WB_HALTED: state <= WB_HALTED;
                default:   state <= WB_IDLE;
            endcase
        end
    end

    register_file #(
        .NUM_REGS(NUM_REGS),
        .DATA_W  (DATA_W),
        .AW      (AW)
    ) u_regs (
        .clk   (clk),
        .reset (reset),
        .weA   (state == WB_COMMIT),
        .waddrA(wbDest),
        .wdataA(wbAlu),
        .weB   ((state == WB_COMMIT) && wbSpecialValid),
        .waddrB(wbDestSpecial),
        .wdataB(wbAluSpecial),
        .raddr1(readReg1In),
        .raddr2(readReg2In),
        .rdata1(readVal1Out),
        .rdata2(readVal2Out)
    );

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage against a behavioural register/retire model.
// Expectations for the same-cycle read follow WB_BYPASS_EN when it is defined.
module tb_writeback_stage;
    import babelfish_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        exValidIn, wbReadyOut, isExecuteSuccessfulIn, killIn;
    logic [63:0] aluResultIn, aluResultSpecialIn;
    logic [3:0]  destRegIn, destRegSpecialIn;
    logic        destRegSpecialValidIn, isMemoryAccessDestIn;
    logic [63:0] memoryAddressDestIn, currentRipIn;
    logic [3:0]  readReg1In, readReg2In;
    logic [63:0] readVal1Out, readVal2Out;
    logic        storeReqOut;
    logic [63:0] storeAddrOut, storeDataOut;
    logic        storeAckIn;
    logic [63:0] retiredCountOut, lastRipOut;
    logic        haltOut;
    wb_state_t   stateDbgOut;

    int checks = 0;
    int errors = 0;

    logic [63:0] mdl_regs [16];
    logic [63:0] mdl_count;
    logic [63:0] mdl_rip;
    logic [63:0] exp_q [$];

    writeback_stage dut (
        .clk(clk), .reset(reset), .exValidIn(exValidIn), .wbReadyOut(wbReadyOut),
        .isExecuteSuccessfulIn(isExecuteSuccessfulIn), .killIn(killIn),
        .aluResultIn(aluResultIn), .aluResultSpecialIn(aluResultSpecialIn),
        .destRegIn(destRegIn), .destRegSpecialIn(destRegSpecialIn),
        .destRegSpecialValidIn(destRegSpecialValidIn), .isMemoryAccessDestIn(isMemoryAccessDestIn),
        .memoryAddressDestIn(memoryAddressDestIn), .currentRipIn(currentRipIn),
        .readReg1In(readReg1In), .readReg2In(readReg2In),
        .readVal1Out(readVal1Out), .readVal2Out(readVal2Out),
        .storeReqOut(storeReqOut), .storeAddrOut(storeAddrOut), .storeDataOut(storeDataOut),
        .storeAckIn(storeAckIn), .retiredCountOut(retiredCountOut), .lastRipOut(lastRipOut),
        .haltOut(haltOut), .stateDbgOut(stateDbgOut)
    );

    // Clock / reset block: long period leaves room for combinational read scans.
    always #50 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mdl_regs[i] = '0;
        mdl_count = '0;
        mdl_rip   = '0;
        exp_q.delete();
    endtask

    // Register results are written primary first, special second, so special wins.
    task automatic model_commit(input logic [3:0] d, input logic [63:0] a, input logic sv,
                                input logic [3:0] ds, input logic [63:0] aSpec, input logic [63:0] rip);
        mdl_regs[d] = a;
        if (sv) mdl_regs[ds] = aSpec;
        mdl_count = mdl_count + 64'd1;
        mdl_rip   = rip;
    endtask

    task automatic idle_inputs();
        exValidIn = 0; isExecuteSuccessfulIn = 0; killIn = 0;
        aluResultIn = '0; aluResultSpecialIn = '0; destRegIn = '0; destRegSpecialIn = '0;
        destRegSpecialValidIn = 0; isMemoryAccessDestIn = 0; memoryAddressDestIn = '0;
        currentRipIn = '0; readReg1In = '0; readReg2In = '0; storeAckIn = 0;
    endtask

    // Driver: presents one instruction while in IDLE; returns at posedge+1 after capture.
    task automatic drive_op(input logic succ, input logic kill, input logic mem, input logic sv,
                            input logic [3:0] d, input logic [3:0] ds, input logic [63:0] a,
                            input logic [63:0] aSpec, input logic [63:0] addr, input logic [63:0] rip);
        exValidIn = 1; isExecuteSuccessfulIn = succ; killIn = kill; isMemoryAccessDestIn = mem;
        destRegSpecialValidIn = sv; destRegIn = d; destRegSpecialIn = ds; aluResultIn = a;
        aluResultSpecialIn = aSpec; memoryAddressDestIn = addr; currentRipIn = rip;
        @(posedge clk); #1;
        exValidIn = 0; killIn = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        model_reset();
        checks++; if (wbReadyOut !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", wbReadyOut); end
        checks++; if (stateDbgOut !== WB_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", stateDbgOut, WB_IDLE); end
        checks++; if (storeReqOut !== 1'b0 || haltOut !== 1'b0) begin errors++; $display("FAIL reset_flags: got req=%b halt=%b expected 0 0", storeReqOut, haltOut); end
        checks++; if (storeAddrOut !== 64'h0 || storeDataOut !== 64'h0) begin errors++; $display("FAIL reset_store: got %h %h expected 0 0", storeAddrOut, storeDataOut); end
        checks++; if (retiredCountOut !== 64'h0 || lastRipOut !== 64'h0) begin errors++; $display("FAIL reset_count: got %h %h expected 0 0", retiredCountOut, lastRipOut); end
        for (int i = 0; i < 16; i++) begin
            readReg1In = 4'(i); readReg2In = 4'(15 - i); #1;
            checks++; if (readVal1Out !== mdl_regs[i]) begin errors++; $display("FAIL reset_reg%0d: got %h expected %h", i, readVal1Out, mdl_regs[i]); end
            checks++; if (readVal2Out !== mdl_regs[15 - i]) begin errors++; $display("FAIL reset_reg%0d: got %h expected %h", 15 - i, readVal2Out, mdl_regs[15 - i]); end
        end
    endtask

    task automatic test_reg_commit();
        drive_op(1, 0, 0, 0, 4'd3, 4'd0, 64'h1234, 64'h0, 64'h0, 64'h10);
        checks++; if (wbReadyOut !== 1'b0) begin errors++; $display("FAIL commit_busy: got %b expected 0", wbReadyOut); end
        checks++; if (stateDbgOut !== WB_COMMIT) begin errors++; $display("FAIL commit_state: got %0d expected %0d", stateDbgOut, WB_COMMIT); end
        @(posedge clk); #1;
        model_commit(4'd3, 64'h1234, 0, 4'd0, 64'h0, 64'h10);
        readReg1In = 4'd3; #1;
        checks++; if (wbReadyOut !== 1'b1) begin errors++; $display("FAIL commit_ready: got %b expected 1", wbReadyOut); end
        checks++; if (readVal1Out !== mdl_regs[3]) begin errors++; $display("FAIL commit_read: got %h expected %h", readVal1Out, mdl_regs[3]); end
        checks++; if (retiredCountOut !== mdl_count) begin errors++; $display("FAIL commit_count: got %0d expected %0d", retiredCountOut, mdl_count); end
        checks++; if (lastRipOut !== mdl_rip) begin errors++; $display("FAIL commit_rip: got %h expected %h", lastRipOut, mdl_rip); end
    endtask

    task automatic test_mul_dual();
        drive_op(1, 0, 0, 1, REG_RAX, REG_RDX, 64'h5, 64'h9, 64'h0, 64'h20);
        @(posedge clk); #1;
        model_commit(REG_RAX, 64'h5, 1, REG_RDX, 64'h9, 64'h20);
        readReg1In = REG_RAX; readReg2In = REG_RDX; #1;
        checks++; if (readVal1Out !== 64'h5) begin errors++; $display("FAIL mul_rax: got %h expected 5", readVal1Out); end
        checks++; if (readVal2Out !== 64'h9) begin errors++; $display("FAIL mul_rdx: got %h expected 9", readVal2Out); end
        drive_op(1, 0, 0, 1, REG_RDX, REG_RDX, 64'h7, 64'h9, 64'h0, 64'h24);
        @(posedge clk); #1;
        model_commit(REG_RDX, 64'h7, 1, REG_RDX, 64'h9, 64'h24);
        readReg2In = REG_RDX; #1;
        checks++; if (readVal2Out !== mdl_regs[2]) begin errors++; $display("FAIL mul_same_dest: got %h expected %h", readVal2Out, mdl_regs[2]); end
        checks++; if (retiredCountOut !== mdl_count) begin errors++; $display("FAIL mul_count: got %0d expected %0d", retiredCountOut, mdl_count); end
    endtask

    task automatic test_store();
        drive_op(1, 0, 1, 0, 4'd7, 4'd0, 64'hAB, 64'h0, 64'h1000, 64'h30);
        exp_q.push_back(64'hAB);
        for (int k = 0; k < 4; k++) begin
            storeAckIn = (k == 3);
            checks++; if (storeReqOut !== 1'b1 || storeAddrOut !== 64'h1000 || storeDataOut !== exp_q[0])
                begin errors++; $display("FAIL store_hold%0d: got req=%b addr=%h data=%h expected 1 1000 %h", k, storeReqOut, storeAddrOut, storeDataOut, exp_q[0]); end
            checks++; if (retiredCountOut !== mdl_count) begin errors++; $display("FAIL store_wait_count%0d: got %0d expected %0d", k, retiredCountOut, mdl_count); end
            @(posedge clk); #1;
        end
        storeAckIn = 0;
        void'(exp_q.pop_front());
        mdl_count = mdl_count + 64'd1; mdl_rip = 64'h30;
        checks++; if (storeReqOut !== 1'b0) begin errors++; $display("FAIL store_drop: got %b expected 0", storeReqOut); end
        checks++; if (retiredCountOut !== mdl_count || lastRipOut !== mdl_rip) begin errors++; $display("FAIL store_retire: got %0d %h expected %0d %h", retiredCountOut, lastRipOut, mdl_count, mdl_rip); end
        for (int i = 0; i < 16; i++) begin
            readReg1In = 4'(i); #1;
            checks++; if (readVal1Out !== mdl_regs[i]) begin errors++; $display("FAIL store_reg%0d: got %h expected %h", i, readVal1Out, mdl_regs[i]); end
        end
    endtask

    task automatic test_unsuccessful();
        drive_op(0, 0, 0, 1, 4'd3, 4'd4, 64'hDEAD, 64'hBEEF, 64'h0, 64'h40);
        checks++; if (wbReadyOut !== 1'b1) begin errors++; $display("FAIL unsucc_ready: got %b expected 1", wbReadyOut); end
        drive_op(0, 0, 1, 0, 4'd3, 4'd0, 64'hDEAD, 64'h0, 64'h2000, 64'h44);
        checks++; if (storeReqOut !== 1'b0) begin errors++; $display("FAIL unsucc_store: got %b expected 0", storeReqOut); end
        @(posedge clk); #1;
        readReg1In = 4'd3; readReg2In = 4'd4; #1;
        checks++; if (readVal1Out !== mdl_regs[3] || readVal2Out !== mdl_regs[4]) begin errors++; $display("FAIL unsucc_regs: got %h %h expected %h %h", readVal1Out, readVal2Out, mdl_regs[3], mdl_regs[4]); end
        checks++; if (retiredCountOut !== mdl_count || lastRipOut !== mdl_rip) begin errors++; $display("FAIL unsucc_count: got %0d %h expected %0d %h", retiredCountOut, lastRipOut, mdl_count, mdl_rip); end
    endtask

    task automatic test_bypass();
        logic [63:0] exp5, exp6;
        drive_op(1, 0, 0, 0, 4'd5, 4'd0, 64'h55, 64'h0, 64'h0, 64'h50);
        @(posedge clk); #1;
        model_commit(4'd5, 64'h55, 0, 4'd0, 64'h0, 64'h50);
        drive_op(1, 0, 0, 1, 4'd5, 4'd5, 64'h111, 64'h222, 64'h0, 64'h54);
`ifdef WB_BYPASS_EN
        exp5 = 64'h222;
`else
        exp5 = mdl_regs[5];
`endif
        readReg1In = 4'd5; readReg2In = 4'd1; #1;
        checks++; if (readVal1Out !== exp5) begin errors++; $display("FAIL bypass_both: got %h expected %h", readVal1Out, exp5); end
        checks++; if (readVal2Out !== mdl_regs[1]) begin errors++; $display("FAIL bypass_other: got %h expected %h", readVal2Out, mdl_regs[1]); end
        @(posedge clk); #1;
        model_commit(4'd5, 64'h111, 1, 4'd5, 64'h222, 64'h54);
        drive_op(1, 0, 0, 0, 4'd6, 4'd0, 64'h666, 64'h0, 64'h0, 64'h58);
`ifdef WB_BYPASS_EN
        exp6 = 64'h666;
`else
        exp6 = mdl_regs[6];
`endif
        readReg2In = 4'd6; #1;
        checks++; if (readVal2Out !== exp6) begin errors++; $display("FAIL bypass_primary: got %h expected %h", readVal2Out, exp6); end
        @(posedge clk); #1;
        model_commit(4'd6, 64'h666, 0, 4'd0, 64'h0, 64'h58);
        readReg1In = 4'd5; readReg2In = 4'd6; #1;
        checks++; if (readVal1Out !== mdl_regs[5] || readVal2Out !== mdl_regs[6]) begin errors++; $display("FAIL bypass_after: got %h %h expected %h %h", readVal1Out, readVal2Out, mdl_regs[5], mdl_regs[6]); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int kind;
            int delay;
            logic [3:0]  d, ds;
            logic [63:0] a, aSpec, addr, rip;
            logic        sv;
            kind = $urandom_range(0, 3);
            d = 4'($urandom_range(0, 15)); ds = 4'($urandom_range(0, 15));
            a = {$urandom, $urandom}; aSpec = {$urandom, $urandom};
            addr = {$urandom, $urandom}; rip = {32'h0, $urandom};
            sv = 1'($urandom_range(0, 1));
            if (kind <= 1) begin
                drive_op(1, 0, 0, sv, d, ds, a, aSpec, addr, rip);
                @(posedge clk); #1;
                model_commit(d, a, sv, ds, aSpec, rip);
            end else if (kind == 2) begin
                delay = $urandom_range(0, 3);
                drive_op(1, 0, 1, sv, d, ds, a, aSpec, addr, rip);
                exp_q.push_back(a);
                for (int k = 0; k <= delay; k++) begin
                    storeAckIn = (k == delay);
                    checks++; if (storeReqOut !== 1'b1 || storeAddrOut !== addr || storeDataOut !== exp_q[0])
                        begin errors++; $display("FAIL rnd_store%0d: got req=%b addr=%h data=%h expected 1 %h %h", n, storeReqOut, storeAddrOut, storeDataOut, addr, exp_q[0]); end
                    @(posedge clk); #1;
                end
                storeAckIn = 0;
                void'(exp_q.pop_front());
                mdl_count = mdl_count + 64'd1; mdl_rip = rip;
            end else begin
                drive_op(0, 0, 1'($urandom_range(0, 1)), sv, d, ds, a, aSpec, addr, rip);
            end
            readReg1In = d; readReg2In = ds; #1;
            checks++; if (readVal1Out !== mdl_regs[d] || readVal2Out !== mdl_regs[ds])
                begin errors++; $display("FAIL rnd_read%0d: got %h %h expected %h %h", n, readVal1Out, readVal2Out, mdl_regs[d], mdl_regs[ds]); end
            checks++; if (retiredCountOut !== mdl_count || lastRipOut !== mdl_rip || wbReadyOut !== 1'b1)
                begin errors++; $display("FAIL rnd_retire%0d: got %0d %h %b expected %0d %h 1", n, retiredCountOut, lastRipOut, wbReadyOut, mdl_count, mdl_rip); end
        end
    endtask

    task automatic test_reset_mid_store();
        drive_op(1, 0, 1, 0, 4'd2, 4'd0, 64'hCAFE, 64'h0, 64'h3000, 64'h60);
        @(posedge clk); #1;
        checks++; if (storeReqOut !== 1'b1) begin errors++; $display("FAIL midrst_pending: got %b expected 1", storeReqOut); end
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        model_reset();
        checks++; if (storeReqOut !== 1'b0 || stateDbgOut !== WB_IDLE || wbReadyOut !== 1'b1)
            begin errors++; $display("FAIL midrst_state: got req=%b state=%0d ready=%b expected 0 %0d 1", storeReqOut, stateDbgOut, wbReadyOut, WB_IDLE); end
        readReg1In = 4'd3; #1;
        checks++; if (retiredCountOut !== mdl_count || readVal1Out !== mdl_regs[3])
            begin errors++; $display("FAIL midrst_clear: got %0d %h expected %0d %h", retiredCountOut, readVal1Out, mdl_count, mdl_regs[3]); end
    endtask

    task automatic test_kill();
        drive_op(1, 1, 0, 0, 4'd3, 4'd0, 64'h77, 64'h0, 64'h0, 64'h400);
        mdl_count = mdl_count + 64'd1; mdl_rip = 64'h400;
        checks++; if (haltOut !== 1'b1 || lastRipOut !== 64'h400 || retiredCountOut !== mdl_count)
            begin errors++; $display("FAIL kill_halt: got %b %h %0d expected 1 400 %0d", haltOut, lastRipOut, retiredCountOut, mdl_count); end
        exValidIn = 1; isExecuteSuccessfulIn = 1; destRegIn = 4'd4; aluResultIn = 64'h99; currentRipIn = 64'h404;
        for (int k = 0; k < 3; k++) begin
            checks++; if (wbReadyOut !== 1'b0 || haltOut !== 1'b1) begin errors++; $display("FAIL kill_stuck%0d: got ready=%b halt=%b expected 0 1", k, wbReadyOut, haltOut); end
            @(posedge clk); #1;
        end
        exValidIn = 0;
        readReg1In = 4'd3; readReg2In = 4'd4; #1;
        checks++; if (readVal1Out !== mdl_regs[3] || readVal2Out !== mdl_regs[4] || retiredCountOut !== mdl_count)
            begin errors++; $display("FAIL kill_nowrite: got %h %h %0d expected %h %h %0d", readVal1Out, readVal2Out, retiredCountOut, mdl_regs[3], mdl_regs[4], mdl_count); end
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        checks++; if (haltOut !== 1'b0 || wbReadyOut !== 1'b1 || retiredCountOut !== 64'h0)
            begin errors++; $display("FAIL kill_reset: got halt=%b ready=%b count=%0d expected 0 1 0", haltOut, wbReadyOut, retiredCountOut); end
    endtask

    initial begin
        test_reset();
        test_reg_commit();
        test_mul_dual();
        test_store();
        test_unsuccessful();
        test_bypass();
        test_random();
        test_reset_mid_store();
        test_kill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
